// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the unified RAM port controller.
//   mem_state_e      : controller FSM states (idle / byte-serial read / write)
//   mem_req_e        : requester identity used by the round-robin arbiter
//   WIDTH_*          : LSB access width encodings
//   IO_ADDR_HI_DEFAULT : addr[17:16] value of the memory-mapped IO region
//   width_to_len()   : access width -> number of byte beats (1/2/4)
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } mem_state_e;

   typedef enum logic {
      REQ_ICACHE = 1'b0,
      REQ_LSB    = 1'b1
   } mem_req_e;

   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b10;

   localparam logic [1:0] IO_ADDR_HI_DEFAULT = 2'b11;

   // instruction fetches are always a full 32-bit word
   localparam logic [2:0] FETCH_LEN = 3'd4;

   // the illegal width 2'b11 is served as a word
   function automatic logic [2:0] width_to_len(input logic [1:0] width);
      case (width)
         WIDTH_BYTE: return 3'd1;
         WIDTH_HALF: return 3'd2;
         WIDTH_WORD: return 3'd4;
         default:    return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
// Two-way round-robin arbiter between the icache and the LSB.
//   i_clk, i_rst_n, i_rdy : clock, synchronous active-low reset, global enable
//   i_req_icache, i_req_lsb : request levels
//   i_accept              : controller is taking a request this cycle
//   o_gnt_icache, o_gnt_lsb : one-hot grant, only while i_accept is high
// r_last remembers the most recent winner and only moves on an accepted grant,
// so a requester that is merely waiting never loses its turn.
// -----------------------------------------------------------------------------
module mem_rr_arbiter
   import mem_ctrl_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_rdy,
   input  logic i_req_icache,
   input  logic i_req_lsb,
   input  logic i_accept,
   output logic o_gnt_icache,
   output logic o_gnt_lsb
);

   mem_req_e r_last;

   always_comb begin
      o_gnt_icache = i_accept && i_req_icache && (!i_req_lsb || (r_last == REQ_LSB));
      o_gnt_lsb    = i_accept && i_req_lsb && !o_gnt_icache;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_last <= REQ_LSB;
      end else if (i_rdy && i_accept) begin
         r_last <= o_gnt_icache ? REQ_ICACHE : REQ_LSB;
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Owns the byte-wide unified RAM port and shares it between icache misses
// (32-bit fetches) and LSB loads/stores. Each request is serialised into 1/2/4
// byte beats; read bytes are reassembled little-endian and a 1-cycle done pulse
// is returned to the requester that was granted.
// Ports:
//   clk_in, rst_n_in, rdy_in : clock, synchronous active-low reset, global enable
//   clear_in                 : flush; aborts reads, never an in-flight store
//   io_buffer_full           : stalls write beats into the IO region
//   mem_din/mem_dout/mem_a/mem_wr : RAM port (read data one cycle after address)
//   icache_*                 : fetch request, done pulse, fetched word
//   lsb_*                    : load/store request, done pulse, zero-extended data
//   busy_out                 : controller is not idle
// -----------------------------------------------------------------------------
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEFAULT
)
(
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        clear_in,
   input  logic        io_buffer_full,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        icache_miss_in,
   input  logic [31:0] icache_addr_in,
   output logic        icache_valid_out,
   output logic [31:0] icache_instr_out,
   input  logic        lsb_req_in,
   input  logic        lsb_wr_in,
   input  logic [1:0]  lsb_width_in,
   input  logic [31:0] lsb_addr_in,
   input  logic [31:0] lsb_data_in,
   output logic        lsb_valid_out,
   output logic [31:0] lsb_data_out,
   output logic        busy_out
);

   mem_state_e  r_state;
   mem_state_e  w_state_nxt;
   mem_req_e    r_owner;
   logic [2:0]  r_cnt;
   logic [2:0]  r_len;
   logic [31:0] r_mem_a;
   logic [7:0]  r_mem_dout;
   logic        r_mem_wr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [31:0] r_icache_instr;
   logic [31:0] r_lsb_data;
   logic        r_icache_valid;
   logic        r_lsb_valid;

   logic        w_accept;
   logic        w_gnt_icache;
   logic        w_gnt_lsb;
   logic        w_io_stall;
   logic        w_rd_last;
   logic        w_wr_last;
   logic [31:0] w_rdata_nxt;

   // No grant while a done pulse is out: the finished requester still holds
   // its request level during that cycle and must not be served twice.
   assign w_accept = (r_state == MEM_IDLE) && !clear_in && !r_icache_valid &&
                     !r_lsb_valid && (icache_miss_in || lsb_req_in);

   assign w_io_stall = (r_mem_a[17:16] == IO_ADDR_HI) && io_buffer_full;

   // READ: r_cnt counts cycles spent in READ; byte r_cnt-1 is on mem_din
   assign w_rd_last = (r_cnt == r_len);
   // WRITE: r_cnt is the index of the byte currently on the port
   assign w_wr_last = ((r_cnt + 3'd1) == r_len);

   mem_rr_arbiter u_arb (
      .i_clk        (clk_in),
      .i_rst_n      (rst_n_in),
      .i_rdy        (rdy_in),
      .i_req_icache (icache_miss_in),
      .i_req_lsb    (lsb_req_in),
      .i_accept     (w_accept),
      .o_gnt_icache (w_gnt_icache),
      .o_gnt_lsb    (w_gnt_lsb)
   );

   // read data with the byte currently on mem_din merged in
   always_comb begin
      w_rdata_nxt = r_rdata;
      case (r_cnt)
         3'd1:    w_rdata_nxt[7:0]   = mem_din;
         3'd2:    w_rdata_nxt[15:8]  = mem_din;
         3'd3:    w_rdata_nxt[23:16] = mem_din;
         3'd4:    w_rdata_nxt[31:24] = mem_din;
         default: ;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_state <= MEM_IDLE;
      end else if (rdy_in) begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MEM_IDLE: begin
            if (w_accept) begin
               w_state_nxt = (w_gnt_lsb && lsb_wr_in) ? MEM_WRITE : MEM_READ;
            end
         end
         MEM_READ: begin
            if (clear_in || w_rd_last) begin
               w_state_nxt = MEM_IDLE;
            end
         end
         MEM_WRITE: begin
            if (!w_io_stall && w_wr_last) begin
               w_state_nxt = MEM_IDLE;
            end
         end
         default: w_state_nxt = MEM_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy_out = (r_state != MEM_IDLE);
      mem_wr   = r_mem_wr && !w_io_stall;
   end

   // datapath: beat counter, address walk, store shift, read assembly
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_owner        <= REQ_ICACHE;
         r_cnt          <= '0;
         r_len          <= '0;
         r_mem_a        <= '0;
         r_mem_dout     <= '0;
         r_mem_wr       <= 1'b0;
         r_wdata        <= '0;
         r_rdata        <= '0;
         r_icache_instr <= '0;
         r_lsb_data     <= '0;
         r_icache_valid <= 1'b0;
         r_lsb_valid    <= 1'b0;
      end else if (rdy_in) begin
         r_icache_valid <= 1'b0;
         r_lsb_valid    <= 1'b0;
         case (r_state)
            MEM_IDLE: begin
               if (w_accept) begin
                  r_cnt   <= '0;
                  r_rdata <= '0;
                  if (w_gnt_icache) begin
                     r_owner  <= REQ_ICACHE;
                     r_len    <= FETCH_LEN;
                     r_mem_a  <= icache_addr_in;
                     r_mem_wr <= 1'b0;
                  end else begin
                     r_owner  <= REQ_LSB;
                     r_len    <= width_to_len(lsb_width_in);
                     r_mem_a  <= lsb_addr_in;
                     r_mem_wr <= lsb_wr_in;
                     if (lsb_wr_in) begin
                        r_mem_dout <= lsb_data_in[7:0];
                        r_wdata    <= {8'h00, lsb_data_in[31:8]};
                     end
                  end
               end
            end
            MEM_READ: begin
               if (!clear_in) begin
                  if (w_rd_last) begin
                     if (r_owner == REQ_ICACHE) begin
                        r_icache_instr <= w_rdata_nxt;
                        r_icache_valid <= 1'b1;
                     end else begin
                        r_lsb_data  <= w_rdata_nxt;
                        r_lsb_valid <= 1'b1;
                     end
                  end else begin
                     r_cnt   <= r_cnt + 3'd1;
                     r_rdata <= w_rdata_nxt;
                     // stop walking once the last byte address has been issued
                     if ((r_cnt + 3'd1) < r_len) begin
                        r_mem_a <= r_mem_a + 32'd1;
                     end
                  end
               end
            end
            MEM_WRITE: begin
               if (!w_io_stall) begin
                  if (w_wr_last) begin
                     r_mem_wr    <= 1'b0;
                     r_lsb_valid <= 1'b1;
                  end else begin
                     r_cnt      <= r_cnt + 3'd1;
                     r_mem_a    <= r_mem_a + 32'd1;
                     r_mem_dout <= r_wdata[7:0];
                     r_wdata    <= {8'h00, r_wdata[31:8]};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_a            = r_mem_a;
   assign mem_dout         = r_mem_dout;
   assign icache_valid_out = r_icache_valid;
   assign icache_instr_out = r_icache_instr;
   assign lsb_valid_out    = r_lsb_valid;
   assign lsb_data_out     = r_lsb_data;

endmodule
